// File: rtl/nms_window_ctrl.sv
// nms_window_ctrl
// Sequencer for the 3-row magnitude/angle line buffer ahead of non-maximum
// suppression. Accepts the gradient pixel stream, drives the buffer load
// strobe, injects IMG_W+1 zero pixels at end of frame so the last row drains,
// and tags each emitted 3x3 window with its centre coordinates and a border
// flag. One window leaves per image pixel.

module nms_window_ctrl #(
  parameter int IMG_W = 514,
  parameter int IMG_H = 384
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic                     s_sof,
  output logic                     s_ready,
  output logic                     lb_ld,
  output logic                     lb_zero,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     win_border,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int NPIX  = IMG_W * IMG_H;
  // Load counter spans pixel loads plus flush loads, plus one terminal count.
  localparam int T_W   = $clog2(NPIX + IMG_W + 2);

  localparam logic [T_W-1:0]   T_FIRST   = T_W'(IMG_W + 1);
  localparam logic [T_W-1:0]   T_LASTPIX = T_W'(NPIX - 1);
  localparam logic [T_W-1:0]   T_LAST    = T_W'(NPIX + IMG_W);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [T_W-1:0]   r_t;
  logic [T_W-1:0]   w_idx;
  logic             w_start;
  logic             w_accept;
  logic             w_emit;
  logic             w_first;
  logic [ROW_W-1:0] w_row_nxt;
  logic [COL_W-1:0] w_col_nxt;

  // A centre on the outer ring of the image has an incomplete neighbourhood.
  function automatic logic f_border(input logic [ROW_W-1:0] row,
                                    input logic [COL_W-1:0] col);
    return (row == '0) || (row == ROW_MAX) || (col == '0) || (col == COL_MAX);
  endfunction

  // Handshake, load strobe and next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = (r_state != S_FLUSH);
    lb_zero     = (r_state == S_FLUSH);
    w_start     = s_valid & s_sof & s_ready;
    w_accept    = s_valid & s_ready & ((r_state == S_RUN) | s_sof);
    lb_ld       = w_accept | (r_state == S_FLUSH);
    // A frame start makes this load index 0 regardless of the running count.
    w_idx       = w_start ? '0 : r_t;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = (w_idx == T_LASTPIX) ? S_FLUSH : S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept && (w_idx == T_LASTPIX)) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_t == T_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Window emission and the next centre coordinates.
  always_comb begin
    w_emit    = lb_ld && (w_idx >= T_FIRST);
    w_first   = (w_idx == T_FIRST);
    w_row_nxt = win_row;
    w_col_nxt = win_col;
    if (w_start || (w_emit && w_first)) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
    end else if (w_emit) begin
      if (win_col == COL_MAX) begin
        w_col_nxt = '0;
        w_row_nxt = win_row + 1'b1;
      end else begin
        w_col_nxt = win_col + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Load counter: index of the next load within the current frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t <= '0;
    end else if (lb_ld) begin
      r_t <= w_idx + 1'b1;
    end
  end

  // Window tags, registered to line up with the buffer's registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      win_border <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      win_valid  <= w_emit;
      win_row    <= w_row_nxt;
      win_col    <= w_col_nxt;
      win_border <= w_emit & f_border(w_row_nxt, w_col_nxt);
      frame_done <= w_emit & (w_idx == T_LAST);
      frame_err  <= w_start & (r_state == S_RUN);
    end
  end

endmodule

// File: tb/tb_nms_window_ctrl.sv
// Self-checking bench for nms_window_ctrl on a 4x3 image.
module tb_nms_window_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_sof = 1'b0;
  logic       s_ready, lb_ld, lb_zero, win_valid, win_border, frame_done, frame_err;
  logic [1:0] win_row;
  logic [1:0] win_col;

  nms_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .lb_ld(lb_ld), .lb_zero(lb_zero),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .win_border(win_border), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: mode 0=idle 1=run 2=flush.
  int m_mode = 0, m_loads = 0, m_acc = 0, m_fl = 0;
  logic exp_ready, exp_ld, exp_zero, exp_wv, exp_done, exp_err, exp_bord;
  int   exp_row, exp_col;
  logic obs_ready, obs_ld, obs_zero, obs_wv, obs_done, obs_err, obs_bord;
  int   obs_row, obs_col;
  int   win_q[$];

  function automatic int win_code(input int k);
    int r, c, b;
    r = k / W;
    c = k % W;
    b = (r == 0 || r == H-1 || c == 0 || c == W-1) ? 1 : 0;
    return r*1000 + c*100 + b*10 + ((k == N-1) ? 1 : 0);
  endfunction

  task automatic model_step(input logic v, input logic sof, input logic r);
    int pm, li, k;
    logic acc;
    pm        = m_mode;
    exp_ready = (pm != 2);
    exp_zero  = (pm == 2);
    acc       = v && exp_ready && (pm == 1 || sof);
    exp_ld    = acc || (pm == 2);
    exp_err   = acc && sof && (pm == 1);
    if (acc && sof) begin m_loads = 0; m_acc = 0; end
    li       = m_loads;
    exp_wv   = exp_ld && (li >= W+1);
    k        = li - (W+1);
    exp_row  = k / W;
    exp_col  = k % W;
    exp_bord = (exp_row == 0 || exp_row == H-1 || exp_col == 0 || exp_col == W-1);
    exp_done = exp_wv && (k == N-1);
    if (exp_ld) m_loads++;
    if (pm == 2) begin
      m_fl++;
      if (m_fl == W+1) m_mode = 0;
    end else if (acc) begin
      m_acc++;
      if (m_acc == N) begin m_mode = 2; m_fl = 0; end
      else m_mode = 1;
    end
    if (r) begin
      m_mode = 0; m_loads = 0; m_acc = 0; m_fl = 0;
      exp_wv = 0; exp_done = 0; exp_err = 0; exp_bord = 0; exp_row = 0; exp_col = 0;
    end
  endtask

  // One clock: drive at negedge, sample strobes just before posedge,
  // registered outputs at the following negedge.
  task automatic tick(input logic v, input logic sof);
    s_valid = v;
    s_sof   = sof;
    #4;
    obs_ready = s_ready;
    obs_ld    = lb_ld;
    obs_zero  = lb_zero;
    model_step(v, sof, rst);
    @(negedge clk);
    obs_wv   = win_valid;
    obs_done = frame_done;
    obs_err  = frame_err;
    obs_row  = int'(win_row);
    obs_col  = int'(win_col);
    obs_bord = win_border;
    if (win_valid)
      win_q.push_back(int'(win_row)*1000 + int'(win_col)*100 + int'(win_border)*10 + int'(frame_done));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    n_vec++; if (s_ready !== 1'b1)    begin n_err++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    n_vec++; if (lb_ld !== 1'b0)      begin n_err++; $display("FAIL reset_lb_ld got %b want 0", lb_ld); end
    n_vec++; if (lb_zero !== 1'b0)    begin n_err++; $display("FAIL reset_lb_zero got %b want 0", lb_zero); end
    n_vec++; if (win_valid !== 1'b0)  begin n_err++; $display("FAIL reset_win_valid got %b want 0", win_valid); end
    n_vec++; if (win_row !== 2'd0)    begin n_err++; $display("FAIL reset_win_row got %0d want 0", win_row); end
    n_vec++; if (win_col !== 2'd0)    begin n_err++; $display("FAIL reset_win_col got %0d want 0", win_col); end
    n_vec++; if (win_border !== 1'b0) begin n_err++; $display("FAIL reset_win_border got %b want 0", win_border); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_vec++; if (frame_err !== 1'b0)  begin n_err++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
  endtask

  task automatic test_continuous;
    int nflush = 0, nzero = 0, ndone = 0, ninner = 0, first_wv = -1;
    win_q.delete();
    for (int i = 0; i < 20; i++) begin
      tick(i < N, i == 0);
      n_vec++; if ({obs_ready, obs_ld, obs_zero} !== {exp_ready, exp_ld, exp_zero}) begin
        n_err++; $display("FAIL cont_strobes i=%0d got rdy/ld/zero=%b%b%b want %b%b%b", i, obs_ready, obs_ld, obs_zero, exp_ready, exp_ld, exp_zero); end
      n_vec++; if ({obs_wv, obs_done, obs_err} !== {exp_wv, exp_done, exp_err}) begin
        n_err++; $display("FAIL cont_flags i=%0d got wv/done/err=%b%b%b want %b%b%b", i, obs_wv, obs_done, obs_err, exp_wv, exp_done, exp_err); end
      if (exp_wv) begin
        n_vec++; if (obs_row !== exp_row || obs_col !== exp_col || obs_bord !== exp_bord) begin
          n_err++; $display("FAIL cont_centre i=%0d got (%0d,%0d) b=%b want (%0d,%0d) b=%b", i, obs_row, obs_col, obs_bord, exp_row, exp_col, exp_bord); end
      end
      if (!obs_ready) nflush++;
      if (obs_zero) nzero++;
      if (obs_done) ndone++;
      if (obs_wv && !obs_bord) ninner++;
      if (obs_wv && first_wv < 0) first_wv = i;
    end
    n_vec++; if (first_wv !== 5) begin n_err++; $display("FAIL cont_first_window got tick %0d want 5", first_wv); end
    n_vec++; if (nflush !== W+1) begin n_err++; $display("FAIL cont_flush_len got %0d want %0d", nflush, W+1); end
    n_vec++; if (nzero !== W+1)  begin n_err++; $display("FAIL cont_zero_len got %0d want %0d", nzero, W+1); end
    n_vec++; if (ndone !== 1)    begin n_err++; $display("FAIL cont_done_count got %0d want 1", ndone); end
    n_vec++; if (ninner !== 2)   begin n_err++; $display("FAIL cont_interior got %0d want 2", ninner); end
    n_vec++; if (win_q.size() !== N) begin n_err++; $display("FAIL cont_win_count got %0d want %0d", win_q.size(), N); end
    for (int k = 0; k < N && k < win_q.size(); k++) begin
      n_vec++; if (win_q[k] !== win_code(k)) begin n_err++; $display("FAIL cont_win k=%0d got %0d want %0d", k, win_q[k], win_code(k)); end
    end
  endtask

  task automatic test_gaps_junk;
    int beats = 0, i = 0;
    logic v, sof;
    win_q.delete();
    while (i < 80 && !(beats == N && m_mode == 0 && i > 10)) begin
      if (i < 3) begin v = 1'b1; sof = 1'b0; end
      else if (beats == 0) begin v = 1'b1; sof = 1'b1; end
      else if (beats < N) begin v = ($urandom_range(0, 2) != 0); sof = 1'b0; end
      else begin v = 1'b0; sof = 1'b0; end
      tick(v, sof);
      if (v && m_mode != 0 && i >= 3 && beats < N) beats++;
      if (i < 3) begin
        n_vec++; if (obs_ld !== 1'b0) begin n_err++; $display("FAIL junk_ld i=%0d got %b want 0", i, obs_ld); end
      end
      n_vec++; if ({obs_ready, obs_ld, obs_zero} !== {exp_ready, exp_ld, exp_zero}) begin
        n_err++; $display("FAIL gaps_strobes i=%0d got rdy/ld/zero=%b%b%b want %b%b%b", i, obs_ready, obs_ld, obs_zero, exp_ready, exp_ld, exp_zero); end
      n_vec++; if ({obs_wv, obs_done, obs_err} !== {exp_wv, exp_done, exp_err}) begin
        n_err++; $display("FAIL gaps_flags i=%0d got wv/done/err=%b%b%b want %b%b%b", i, obs_wv, obs_done, obs_err, exp_wv, exp_done, exp_err); end
      i++;
    end
    repeat (2) tick(1'b0, 1'b0);
    n_vec++; if (win_q.size() !== N) begin n_err++; $display("FAIL gaps_win_count got %0d want %0d", win_q.size(), N); end
    for (int k = 0; k < N && k < win_q.size(); k++) begin
      n_vec++; if (win_q[k] !== win_code(k)) begin n_err++; $display("FAIL gaps_win k=%0d got %0d want %0d", k, win_q[k], win_code(k)); end
    end
  endtask

  task automatic test_early_sof;
    int nerr_p = 0;
    int expq[$];
    win_q.delete();
    expq.push_back(win_code(0));
    expq.push_back(win_code(1));
    for (int k = 0; k < N; k++) expq.push_back(win_code(k));
    for (int i = 0; i < 7 + N + 8; i++) begin
      tick(i < 7 + N, i == 0 || i == 7);
      n_vec++; if ({obs_ready, obs_ld, obs_zero} !== {exp_ready, exp_ld, exp_zero}) begin
        n_err++; $display("FAIL early_strobes i=%0d got rdy/ld/zero=%b%b%b want %b%b%b", i, obs_ready, obs_ld, obs_zero, exp_ready, exp_ld, exp_zero); end
      n_vec++; if ({obs_wv, obs_done, obs_err} !== {exp_wv, exp_done, exp_err}) begin
        n_err++; $display("FAIL early_flags i=%0d got wv/done/err=%b%b%b want %b%b%b", i, obs_wv, obs_done, obs_err, exp_wv, exp_done, exp_err); end
      if (i == 7) begin
        n_vec++; if (obs_err !== 1'b1) begin n_err++; $display("FAIL early_err_pulse got %b want 1", obs_err); end
      end
      if (obs_err) nerr_p++;
    end
    n_vec++; if (nerr_p !== 1) begin n_err++; $display("FAIL early_err_count got %0d want 1", nerr_p); end
    n_vec++; if (win_q.size() !== expq.size()) begin n_err++; $display("FAIL early_win_count got %0d want %0d", win_q.size(), expq.size()); end
    for (int k = 0; k < expq.size() && k < win_q.size(); k++) begin
      n_vec++; if (win_q[k] !== expq[k]) begin n_err++; $display("FAIL early_win k=%0d got %0d want %0d", k, win_q[k], expq[k]); end
    end
  endtask

  task automatic test_reset_flush;
    int ndone = 0;
    for (int i = 0; i < N + 2; i++) tick(i < N, i == 0);
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    n_vec++; if ({s_ready, lb_ld, lb_zero} !== 3'b100) begin n_err++; $display("FAIL rstfl_strobes got %b%b%b want 100", s_ready, lb_ld, lb_zero); end
    n_vec++; if ({win_valid, win_border, frame_done, frame_err} !== 4'b0000) begin
      n_err++; $display("FAIL rstfl_flags got %b%b%b%b want 0000", win_valid, win_border, frame_done, frame_err); end
    n_vec++; if ({win_row, win_col} !== 4'b0000) begin n_err++; $display("FAIL rstfl_centre got (%0d,%0d) want (0,0)", win_row, win_col); end
    win_q.delete();
    for (int i = 0; i < 6 + N + 8; i++) begin
      tick(i >= 6 && i < 6 + N, i == 6);
      n_vec++; if ({obs_ready, obs_ld, obs_zero} !== {exp_ready, exp_ld, exp_zero}) begin
        n_err++; $display("FAIL rstfl_seq_strobes i=%0d got rdy/ld/zero=%b%b%b want %b%b%b", i, obs_ready, obs_ld, obs_zero, exp_ready, exp_ld, exp_zero); end
      if (i < 6 && obs_done) ndone++;
    end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL rstfl_no_done got %0d want 0", ndone); end
    n_vec++; if (win_q.size() !== N) begin n_err++; $display("FAIL rstfl_win_count got %0d want %0d", win_q.size(), N); end
    for (int k = 0; k < N && k < win_q.size(); k++) begin
      n_vec++; if (win_q[k] !== win_code(k)) begin n_err++; $display("FAIL rstfl_win k=%0d got %0d want %0d", k, win_q[k], win_code(k)); end
    end
  endtask

  task automatic test_random;
    logic v, sof;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      sof = (m_mode == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      tick(v, sof);
      n_vec++; if ({obs_ready, obs_ld, obs_zero} !== {exp_ready, exp_ld, exp_zero}) begin
        n_err++; $display("FAIL rand_strobes i=%0d got rdy/ld/zero=%b%b%b want %b%b%b", i, obs_ready, obs_ld, obs_zero, exp_ready, exp_ld, exp_zero); end
      n_vec++; if ({obs_wv, obs_done, obs_err} !== {exp_wv, exp_done, exp_err}) begin
        n_err++; $display("FAIL rand_flags i=%0d got wv/done/err=%b%b%b want %b%b%b", i, obs_wv, obs_done, obs_err, exp_wv, exp_done, exp_err); end
      if (exp_wv) begin
        n_vec++; if (obs_row !== exp_row || obs_col !== exp_col || obs_bord !== exp_bord) begin
          n_err++; $display("FAIL rand_centre i=%0d got (%0d,%0d) b=%b want (%0d,%0d) b=%b", i, obs_row, obs_col, obs_bord, exp_row, exp_col, exp_bord); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_continuous;
    test_gaps_junk;
    test_early_sof;
    test_reset_flush;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nms_window_ctrl.md
# nms_window_ctrl

Sequencing controller for the 3-row magnitude/angle line buffer that feeds non-maximum suppression in the Canny pipeline. It accepts the gradient pixel stream (20-bit magnitude and 2-bit angle) with a valid/ready handshake and generates the buffer's load strobe. It tracks frame position, injects zero pixels at end of frame so the last row drains, and tags every emitted 3x3 window with its centre coordinates and a border flag. Exactly one window is emitted per image pixel.

## Interface
- IMG_W, 514, pixels per line; equals the line-buffer depth.
- IMG_H, 384, lines per frame.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high. The same rst also clears the line buffer.
- s_valid  in  1  upstream pixel valid.
- s_sof  in  1  marks the first pixel of a frame; qualified by s_valid.
- s_ready  out  1  controller can accept a pixel.
- lb_ld  out  1  line-buffer load strobe.
- lb_zero  out  1  forces the line-buffer PixelData and AngData inputs to 0 (the mux is external).
- win_valid  out  1  the line-buffer outputs this cycle form the window centred at (win_row, win_col).
- win_row  out  $clog2(IMG_H)  centre row of the current window.
- win_col  out  $clog2(IMG_W)  centre column of the current window.
- win_border  out  1  centre lies on row 0, row IMG_H-1, column 0 or column IMG_W-1.
- frame_done  out  1  one-cycle pulse coinciding with the last window of a frame.
- frame_err  out  1  one-cycle pulse when a frame is aborted by an early s_sof.

## Operation
- States:
  - IDLE: s_ready=1. A beat with s_valid & s_sof is accepted as pixel 0, and the controller moves to RUN. Beats without s_sof are discarded, with lb_ld=0.
  - RUN: s_ready=1. Each beat with s_valid is accepted. After pixel IMG_W*IMG_H-1 is accepted, the controller moves to FLUSH.
  - FLUSH: s_ready=0, lb_ld=1 and lb_zero=1 every cycle for exactly IMG_W+1 cycles, then the controller returns to IDLE.
- Load strobe: lb_ld = accept | (state==FLUSH), where accept = s_valid & s_ready & (state==RUN | s_sof). Outside FLUSH, lb_zero=0.
- Load counter t: counts every load, including flush loads. It resets to 0 on a frame start, and its width covers IMG_W*IMG_H+IMG_W+1.
- Window emission:
  - A load with t >= IMG_W+1 produces win_valid=1 on the following cycle, for centre index k = t-(IMG_W+1).
  - win_col and win_row are separate output counters. win_col wraps at IMG_W-1 and increments win_row; both clear to 0 at frame start.
  - win_valid is 0 in every cycle not preceded by a qualifying load. Downstream must ignore the line-buffer outputs in those cycles.
- win_border is derived from the output counters and is valid only while win_valid=1.
- frame_done=1 together with win_valid for k = IMG_W*IMG_H-1, i.e. the cycle after the final flush load.
- Early s_sof:
  - s_sof on an accepted beat in RUN aborts the current frame and pulses frame_err on the next cycle.
  - All counters restart, and that beat becomes pixel 0 of the new frame (lb_ld=1).
  - Windows of the aborted frame are no longer emitted. Buffer contents are stale but are masked by win_border or overwritten.
- s_sof while in IDLE starts a frame with no error. s_sof cannot occur in FLUSH, because s_ready=0.
- Upstream gaps (s_valid=0) in RUN stall everything: no load and no win_valid.

## Timing
- Reset values: state=IDLE, s_ready=1, lb_ld=0, lb_zero=0, win_valid=0, win_row=0, win_col=0, win_border=0, frame_done=0, frame_err=0.
- rst mid-frame returns the controller to IDLE on the next edge, with no frame_done or frame_err pulse.
- s_ready and lb_ld are combinational from the state and inputs.
- win_valid, win_row, win_col, win_border, frame_done and frame_err are registered and align with the line-buffer registered outputs: one cycle after the load.
- Pipeline depth: the window for centre k appears one cycle after load k+IMG_W+1.
- Frame throughput: IMG_W*IMG_H accepted beats plus IMG_W+1 flush cycles.

## Test plan
Use IMG_W=4 and IMG_H=3 for all scenarios.
- **Continuous frame:** 12 beats, s_sof on the first, no gaps. Required: 12 win_valid pulses; the first is 1 cycle after load t=5, with centre (0,0) and border=1.
- **Interior windows:** same stream. Required: centres (1,1) and (1,2) have win_border=0; all other 10 centres have win_border=1.
- **Flush:** after the 12th beat, FLUSH holds s_ready=0 and lb_ld=lb_zero=1 for exactly 5 cycles. Required: frame_done with centre (2,3) one cycle after the 5th flush load, then IDLE.
- **Gaps and junk:** random s_valid gaps in RUN, plus 3 non-sof beats while in IDLE. Required: junk produces lb_ld=0; the window sequence and count are the same as the continuous frame, only stretched in time.
- **Early sof:** s_sof on beat 7. Required: frame_err pulse and counters restart; a full 12-window frame follows from that beat.
- **Reset mid-FLUSH:** rst during the 3rd flush cycle. Required: all outputs at reset values the next cycle and no frame_done; the next s_sof starts a clean frame.
